// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: word-to-serial sequencing controller for a serial
// sequence detector (x, reset, clk, y).
//
// A word accepted on the in_* handshake is shifted MSB-first onto det_x.
// The detector's registered y is sampled once per bit, one cycle late.
// The per-word hit count is returned on the out_* handshake.
//
// Optional build macro: SEQ_CTRL_FLUSH_EN
//   Defined: a one-cycle FLUSH state between IDLE and SHIFT pulses det_reset
//            so that every word is detected independently of history.
//   Undefined: det_reset follows only the controller reset, and detector
//            history carries across words through the idle x=1 cycles.
module seq_detect_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_hit,
  output logic             det_x,
  output logic             det_reset,
  input  logic             det_y
);

  // Controller states. FLUSH exists only in the flushing build.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
`ifdef SEQ_CTRL_FLUSH_EN
    FLUSH = 3'd1,
`endif
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Index of the last bit. The bit index shares the counter width,
  // because 2^CNT_W > WIDTH guarantees that it fits.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state;
  logic [WIDTH-1:0] sreg;       // word being serialized, MSB at the top
  logic [CNT_W-1:0] idx;        // bit currently on det_x during SHIFT
  logic [CNT_W-1:0] cnt;        // detections so far for this word
  logic             sample_en;  // previous cycle was SHIFT, so y is for a bit
  logic [CNT_W-1:0] cnt_nxt;

  // The line idles high. During SHIFT the MSB drives the detector directly,
  // so the bit is valid in the same cycle that it is counted in idx.
  assign det_x = (state == SHIFT) ? sreg[WIDTH-1] : 1'b1;

  // The count is presented straight from the accumulator. It is frozen
  // once the FSM reaches DONE, because sampling stops after DRAIN.
  assign out_count = cnt;

  // Next count: add one sample of y when it belongs to a shifted bit,
  // and saturate at the maximum value instead of wrapping.
  always_comb begin
    cnt_nxt = cnt;
    if (sample_en && det_y && (cnt != CNT_MAX))
      cnt_nxt = cnt + CNT_W'(1);
  end

  // Main FSM: the state, the datapath registers and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= '0;
      idx       <= '0;
      cnt       <= '0;
      sample_en <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      det_reset <= 1'b1;
    end else begin
      // Samples lag the shifted bit by one cycle, matching the detector's
      // registered y. A stale y outside that window is never counted.
      sample_en <= (state == SHIFT);
      det_reset <= 1'b0;
      cnt       <= cnt_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg     <= in_data;
            idx      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
`ifdef SEQ_CTRL_FLUSH_EN
            state     <= FLUSH;
            det_reset <= 1'b1;
`else
            state     <= SHIFT;
`endif
          end
        end
`ifdef SEQ_CTRL_FLUSH_EN
        // det_reset is high for this single cycle while x stays idle high,
        // so the detector starts the word from its initial state.
        FLUSH: begin
          state <= SHIFT;
        end
`endif
        SHIFT: begin
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          idx  <= idx + CNT_W'(1);
          if (idx == LAST_IDX)
            state <= DRAIN;
        end
        // y for the final bit is added on the edge that leaves DRAIN.
        // out_hit therefore looks at the updated count.
        DRAIN: begin
          state     <= DONE;
          out_valid <= 1'b1;
          out_hit   <= (cnt_nxt != '0);
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
